riscv_prefetch_controller: RTL

RISCV_PREFETCH_CONTROLLER -- requirements
Module: riscv_prefetch_controller

---
 rtl/riscv_prefetch_pkg.sv | 15 +
 rtl/riscv_prefetch_fifo.sv | 57 +++++
 rtl/riscv_prefetch_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/riscv_prefetch_pkg.sv
// rtl/riscv_prefetch_pkg.sv - shared constants and FSM state type for the instruction prefetcher
package riscv_prefetch_pkg;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_MAX_OUT = 2;
    // FIFO entry: {err, addr[31:0], rdata[31:0]}
    localparam int ENTRY_W         = 65;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_ACTIVE,
        PF_FLUSH
    } pf_state_e;

endpackage

// File: rtl/riscv_prefetch_fifo.sv
// rtl/riscv_prefetch_fifo.sv - fetched-word FIFO with synchronous clear and gated head output
module riscv_prefetch_fifo
    import riscv_prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic                           valid_o,
    output logic [WIDTH-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i & ~empty;
    // a pop frees the slot the simultaneous push lands in
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = ~empty;
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_prefetch_controller.sv
// rtl/riscv_prefetch_controller.sv - credit-limited instruction prefetcher with branch flush
module riscv_prefetch_controller
    import riscv_prefetch_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int MAX_OUT = DEFAULT_MAX_OUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        trans_valid_o,
    input  logic        trans_ready_i,
    output logic [31:0] trans_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        busy_o
);

    localparam int CW = $clog2(MAX_OUT+1);
    localparam int FW = $clog2(DEPTH+1);

    logic [CW-1:0]      cnt_q, cnt_d, flush_q, flush_d;
    logic [31:0]        next_addr_q, resp_addr_q, branch_addr_al;
    logic [FW-1:0]      fifo_cnt;
    logic [FW:0]        credit_sum;
    logic               accept, push;
    logic [ENTRY_W-1:0] fifo_head;
    pf_state_e          state_q, state_d;

    assign branch_addr_al = branch_addr_i & ~32'h3;
    assign trans_addr_o   = branch_i ? branch_addr_al : next_addr_q;

    // the FIFO is cleared in a branch cycle, so its occupancy frees up immediately
    assign credit_sum    = {{(FW+1-CW){1'b0}}, cnt_q} + (branch_i ? '0 : {1'b0, fifo_cnt});
    assign trans_valid_o = req_i & (cnt_q < CW'(MAX_OUT)) & (credit_sum < (FW+1)'(DEPTH));
    assign accept        = trans_valid_o & trans_ready_i;
    assign push          = resp_valid_i & (flush_q == '0) & ~branch_i;
    assign busy_o        = (cnt_q != '0) | trans_valid_o;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !resp_valid_i)
            cnt_d = cnt_q + 1'b1;
        else if (!accept && resp_valid_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;

        flush_d = flush_q;
        if (branch_i)
            flush_d = (resp_valid_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        else if (resp_valid_i && flush_q != '0)
            flush_d = flush_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PF_IDLE: begin
                if (flush_d != '0)                        state_d = PF_FLUSH;
                else if (trans_valid_o || cnt_d != '0)    state_d = PF_ACTIVE;
            end
            PF_ACTIVE: begin
                if (flush_d != '0)                        state_d = PF_FLUSH;
                else if (cnt_q == '0 && !trans_valid_o)   state_d = PF_IDLE;
            end
            PF_FLUSH: begin
                if (flush_d == '0)
                    state_d = (cnt_d != '0 || trans_valid_o) ? PF_ACTIVE : PF_IDLE;
            end
            default: state_d = PF_IDLE;
        endcase
    end

    // responses are in order, so the pushed address just walks forward from the last redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            flush_q     <= '0;
            next_addr_q <= '0;
            resp_addr_q <= '0;
            state_q     <= PF_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            state_q <= state_d;
            if (accept)
                next_addr_q <= trans_addr_o + 32'd4;
            else if (branch_i)
                next_addr_q <= branch_addr_al;
            if (branch_i)
                resp_addr_q <= branch_addr_al;
            else if (push)
                resp_addr_q <= resp_addr_q + 32'd4;
        end
    end

    riscv_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (branch_i),
        .push_i  (push),
        .wdata_i ({resp_err_i, resp_addr_q, resp_rdata_i}),
        .pop_i   (out_ready_i),
        .valid_o (out_valid_o),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt)
    );

    assign out_err_o   = fifo_head[64];
    assign out_addr_o  = fifo_head[63:32];
    assign out_rdata_o = fifo_head[31:0];

endmodule
